// File: rtl/bram_lsu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : bram_lsu_pkg
// Brief  : Shared types and constants for the BRAM load/store port.
// Rev    : 1.0
// ---------------------------------------------------------------------------
package bram_lsu_pkg;

    localparam int WDATA = 32;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_BAD = 2'b11
    } size_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR      = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    // Illegal size or a lane offset that does not fit the access width.
    function automatic logic req_bad(input size_t sz, input logic [1:0] lane);
        return (sz == SZ_BAD) || ((sz == SZ_H) && lane[0]) ||
               ((sz == SZ_W) && (lane != 2'b00));
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_lsu_port_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : bram_lsu_port_if
// Brief  : Core-side request/response bundle of the BRAM load/store port.
// Rev    : 1.0
// ---------------------------------------------------------------------------
interface bram_lsu_port_if #(
    parameter int WADDR = 10
) ();
    logic               pi_req_valid;
    logic               po_req_ready;
    logic               pi_req_we;
    logic [1:0]         pi_req_size;
    logic               pi_req_unsigned;
    logic [WADDR+1:0]   pi_req_addr;
    logic [31:0]        pi_req_wdata;
    logic               po_rsp_valid;
    logic               pi_rsp_ready;
    logic [31:0]        po_rsp_rdata;
    logic               po_rsp_err;

    modport master (
        output pi_req_valid, pi_req_we, pi_req_size, pi_req_unsigned,
               pi_req_addr, pi_req_wdata, pi_rsp_ready,
        input  po_req_ready, po_rsp_valid, po_rsp_rdata, po_rsp_err
    );

    modport slave (
        input  pi_req_valid, pi_req_we, pi_req_size, pi_req_unsigned,
               pi_req_addr, pi_req_wdata, pi_rsp_ready,
        output po_req_ready, po_rsp_valid, po_rsp_rdata, po_rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/bram_lane_align.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : bram_lane_align
// Brief  : Lane extract/extend for loads and lane merge for sub-word stores.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module bram_lane_align
    import bram_lsu_pkg::*;
(
    input  size_t              i_size,
    input  logic [1:0]         i_lane,
    input  logic               i_unsigned,
    input  logic [WDATA-1:0]   i_rdata,
    input  logic [WDATA-1:0]   i_wdata,
    output logic [WDATA-1:0]   o_load,
    output logic [WDATA-1:0]   o_merge
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_lane)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_size)
            SZ_B:    o_load = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SZ_H:    o_load = {{16{~i_unsigned & w_half[15]}}, w_half};
            default: o_load = i_rdata;
        endcase

        // Bytes outside the addressed lane keep the value read from BRAM.
        o_merge = i_rdata;
        case (i_size)
            SZ_B: begin
                case (i_lane)
                    2'd0:    o_merge[7:0]   = i_wdata[7:0];
                    2'd1:    o_merge[15:8]  = i_wdata[7:0];
                    2'd2:    o_merge[23:16] = i_wdata[7:0];
                    default: o_merge[31:24] = i_wdata[7:0];
                endcase
            end
            SZ_H: begin
                if (i_lane[1]) o_merge[31:16] = i_wdata[15:0];
                else           o_merge[15:0]  = i_wdata[15:0];
            end
            default: o_merge = i_wdata;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/bram_lsu_port.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : bram_lsu_port
// Brief  : Load/store initiator for one BRAM port, RMW for sub-word stores.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module bram_lsu_port #(
    parameter int WADDR = 10,
    parameter int WDATA = 32
) (
    input  wire logic              pi_clk,
    input  wire logic              pi_rst,
    bram_lsu_port_if.slave         bus,
    output logic                   po_bram_en,
    output logic                   po_bram_we,
    output logic [WADDR-1:0]       po_bram_addr,
    output logic [WDATA-1:0]       po_bram_di,
    input  wire logic [WDATA-1:0]  pi_bram_do
);
    import bram_lsu_pkg::*;

    if (WDATA != bram_lsu_pkg::WDATA) begin : g_bad_wdata
        $error("bram_lsu_port: only WDATA=32 is supported");
    end

    state_t              r_state;
    state_t              w_next;
    logic [WADDR+1:0]    r_addr;
    size_t               r_size;
    logic                r_we;
    logic                r_uns;
    logic [WDATA-1:0]    r_rdata;
    logic [WDATA-1:0]    r_di;
    logic                r_err;

    logic                w_req_ready;
    logic                w_en;
    logic                w_we;
    logic                w_rsp_valid;
    logic                w_accept;
    logic                w_req_bad;
    size_t               w_req_size;
    logic [WDATA-1:0]    w_load;
    logic [WDATA-1:0]    w_merge;

    assign w_req_size = size_t'(bus.pi_req_size);
    assign w_req_bad  = req_bad(w_req_size, bus.pi_req_addr[1:0]);

    always_ff @(posedge pi_clk) begin
        if (pi_rst) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_req_ready = 1'b0;
        w_en        = 1'b0;
        w_we        = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.pi_req_valid) begin
                    if (w_req_bad)                                 w_next = ST_RESP;
                    else if (bus.pi_req_we && w_req_size == SZ_W)  w_next = ST_WR;
                    else                                           w_next = ST_RD;
                end
            end
            ST_RD: begin
                w_en   = 1'b1;
                w_next = ST_RD_WAIT;
            end
            ST_RD_WAIT: w_next = r_we ? ST_WR : ST_RESP;
            ST_WR: begin
                w_en   = 1'b1;
                w_we   = 1'b1;
                w_next = ST_RESP;
            end
            ST_RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.pi_rsp_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Gating by reset keeps an interrupted RMW from landing its write.
    assign bus.po_req_ready = w_req_ready & ~pi_rst;
    assign po_bram_en       = w_en & ~pi_rst;
    assign po_bram_we       = w_we & ~pi_rst;
    assign po_bram_addr     = r_addr[WADDR+1:2];
    assign po_bram_di       = r_di;
    assign bus.po_rsp_valid = w_rsp_valid;
    assign bus.po_rsp_rdata = r_rdata;
    assign bus.po_rsp_err   = r_err;

    assign w_accept = bus.po_req_ready & bus.pi_req_valid;

    bram_lane_align u_align (
        .i_size     (r_size),
        .i_lane     (r_addr[1:0]),
        .i_unsigned (r_uns),
        .i_rdata    (pi_bram_do),
        .i_wdata    (r_di),
        .o_load     (w_load),
        .o_merge    (w_merge)
    );

    always_ff @(posedge pi_clk) begin
        if (pi_rst) begin
            r_addr  <= '0;
            r_size  <= SZ_B;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_rdata <= '0;
            r_di    <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= bus.pi_req_addr;
                r_size  <= w_req_size;
                r_we    <= bus.pi_req_we;
                r_uns   <= bus.pi_req_unsigned;
                r_rdata <= '0;
                r_di    <= bus.pi_req_wdata;
                r_err   <= w_req_bad;
            end
            if (r_state == ST_RD_WAIT) begin
                if (r_we) r_di    <= w_merge;
                else      r_rdata <= w_load;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_bram_lsu_port.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_bram_lsu_port
// Brief  : Directed and random load/store traffic against a dual-port BRAM.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module tb_bram_lsu_port;
    localparam int WADDR = 10;
    localparam int NWORDS = 32;

    logic pi_clk = 1'b0;
    logic pi_rst = 1'b1;
    always #5 pi_clk = ~pi_clk;

    bram_lsu_port_if #(.WADDR(WADDR)) lsu_bus ();

    logic              po_bram_en;
    logic              po_bram_we;
    logic [WADDR-1:0]  po_bram_addr;
    logic [31:0]       po_bram_di;
    logic [31:0]       pi_bram_do;

    bram_lsu_port #(.WADDR(WADDR), .WDATA(32)) dut (
        .pi_clk       (pi_clk),
        .pi_rst       (pi_rst),
        .bus          (lsu_bus),
        .po_bram_en   (po_bram_en),
        .po_bram_we   (po_bram_we),
        .po_bram_addr (po_bram_addr),
        .po_bram_di   (po_bram_di),
        .pi_bram_do   (pi_bram_do)
    );

    // Dual-port BRAM: port A on the DUT, port B used as a backdoor.
    logic [31:0]      ram [0:(1<<WADDR)-1];
    logic             b_we = 1'b0;
    logic [WADDR-1:0] b_addr = '0;
    logic [31:0]      b_di = '0;
    always @(posedge pi_clk) begin
        if (po_bram_en) begin
            if (po_bram_we) ram[po_bram_addr] <= po_bram_di;
            else            pi_bram_do <= ram[po_bram_addr];
        end
        if (b_we) ram[b_addr] <= b_di;
    end

    int en_cnt = 0;
    int we_cnt = 0;
    always @(posedge pi_clk) begin
        if (po_bram_en)               en_cnt++;
        if (po_bram_en && po_bram_we) we_cnt++;
    end

    logic [31:0] ref_mem [0:NWORDS-1];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input int sz,
                                             input int off, input bit uns);
        logic [31:0] v;
        v = w >> (8 * off);
        if (sz == 0) return uns ? (v & 32'hFF)   : ((v & 32'h80)   != 0 ? (v | 32'hFFFFFF00) : (v & 32'hFF));
        if (sz == 1) return uns ? (v & 32'hFFFF) : ((v & 32'h8000) != 0 ? (v | 32'hFFFF0000) : (v & 32'hFFFF));
        return w;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input int sz,
                                              input int off, input logic [31:0] d);
        logic [31:0] m;
        m = (sz == 0) ? 32'hFF : (sz == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
        m = m << (8 * off);
        return (w & ~m) | ((d << (8 * off)) & m);
    endfunction

    task automatic bwrite(input int idx, input logic [31:0] v);
        b_we = 1'b1; b_addr = WADDR'(idx); b_di = v;
        @(posedge pi_clk); #1;
        b_we = 1'b0;
        ref_mem[idx] = v;
    endtask

    task automatic drive_req(input bit we, input logic [1:0] sz, input bit uns,
                             input logic [11:0] a, input logic [31:0] wd, input string tag);
        int cyc;
        lsu_bus.pi_req_valid    = 1'b1;
        lsu_bus.pi_req_we       = we;
        lsu_bus.pi_req_size     = sz;
        lsu_bus.pi_req_unsigned = uns;
        lsu_bus.pi_req_addr     = a;
        lsu_bus.pi_req_wdata    = wd;
        cyc = 0;
        while (!lsu_bus.po_req_ready && cyc < 20) begin
            @(posedge pi_clk); #1; cyc++;
        end
        chk({tag, "/ready"}, 32'(lsu_bus.po_req_ready), 32'd1);
        @(posedge pi_clk); #1;
        lsu_bus.pi_req_valid = 1'b0;
    endtask

    task automatic do_req(input bit we, input logic [1:0] sz, input bit uns,
                          input logic [11:0] a, input logic [31:0] wd,
                          input int hold, input string tag);
        bit err;
        int lat, cyc, e0, w0, exp_en, exp_we, widx, off, s;
        logic [31:0] exp_rd;
        widx = int'(a[11:2]);
        off  = int'(a[1:0]);
        s    = int'(sz);
        err  = (s == 3) || (s == 1 && off % 2 != 0) || (s == 2 && off != 0);
        exp_rd = 32'h0;
        exp_we = 0;
        if (err) begin
            lat = 1; exp_en = 0;
        end else if (!we) begin
            lat = 3; exp_en = 1;
            exp_rd = ref_load(ref_mem[widx], s, off, uns);
        end else begin
            lat    = (s == 2) ? 2 : 4;
            exp_en = (s == 2) ? 1 : 2;
            exp_we = 1;
            ref_mem[widx] = ref_store(ref_mem[widx], s, off, wd);
        end
        lsu_bus.pi_rsp_ready = 1'b0;
        e0 = en_cnt; w0 = we_cnt;
        drive_req(we, sz, uns, a, wd, tag);
        cyc = 1;
        while (!lsu_bus.po_rsp_valid && cyc < 20) begin
            @(posedge pi_clk); #1; cyc++;
        end
        chk({tag, "/latency"}, 32'(cyc), 32'(lat));
        chk({tag, "/err"},     32'(lsu_bus.po_rsp_err), 32'(err));
        chk({tag, "/rdata"},   lsu_bus.po_rsp_rdata, exp_rd);
        chk({tag, "/en_cnt"},  32'(en_cnt - e0), 32'(exp_en));
        chk({tag, "/we_cnt"},  32'(we_cnt - w0), 32'(exp_we));
        for (int i = 0; i < hold; i++) begin
            @(posedge pi_clk); #1;
            chk({tag, "/hold_valid"}, 32'(lsu_bus.po_rsp_valid), 32'd1);
            chk({tag, "/hold_rdata"}, lsu_bus.po_rsp_rdata, exp_rd);
            chk({tag, "/hold_ready"}, 32'(lsu_bus.po_req_ready), 32'd0);
        end
        lsu_bus.pi_rsp_ready = 1'b1;
        @(posedge pi_clk); #1;
        lsu_bus.pi_rsp_ready = 1'b0;
        chk({tag, "/rsp_done"}, 32'(lsu_bus.po_rsp_valid), 32'd0);
        chk({tag, "/idle"},     32'(lsu_bus.po_req_ready), 32'd1);
        if (we && !err) chk({tag, "/mem"}, ram[widx], ref_mem[widx]);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "/req_ready"}, 32'(lsu_bus.po_req_ready), 32'd0);
        chk({tag, "/rsp_valid"}, 32'(lsu_bus.po_rsp_valid), 32'd0);
        chk({tag, "/rdata"},     lsu_bus.po_rsp_rdata, 32'd0);
        chk({tag, "/err"},       32'(lsu_bus.po_rsp_err), 32'd0);
        chk({tag, "/en"},        32'(po_bram_en), 32'd0);
        chk({tag, "/we"},        32'(po_bram_we), 32'd0);
        chk({tag, "/addr"},      32'(po_bram_addr), 32'd0);
        chk({tag, "/di"},        po_bram_di, 32'd0);
    endtask

    initial begin
        int cyc;
        lsu_bus.pi_req_valid    = 1'b0;
        lsu_bus.pi_req_we       = 1'b0;
        lsu_bus.pi_req_size     = 2'b00;
        lsu_bus.pi_req_unsigned = 1'b0;
        lsu_bus.pi_req_addr     = '0;
        lsu_bus.pi_req_wdata    = '0;
        lsu_bus.pi_rsp_ready    = 1'b0;

        for (int i = 0; i < NWORDS; i++) bwrite(i, $urandom);
        @(posedge pi_clk); #1;
        chk_reset_outputs("reset");
        pi_rst = 1'b0;
        @(posedge pi_clk); #1;

        // Directed steps
        bwrite(5, 32'h8899AABB);
        do_req(1'b0, 2'b00, 1'b0, 12'h016, 32'h0, 0, "lb_0x16");
        do_req(1'b0, 2'b01, 1'b1, 12'h014, 32'h0, 0, "lhu_0x14");
        do_req(1'b0, 2'b10, 1'b0, 12'h014, 32'h0, 0, "lw_0x14");
        do_req(1'b1, 2'b00, 1'b0, 12'h015, 32'h5A, 0, "sb_0x15");
        chk("sb_word5", ram[5], 32'h88995ABB);
        do_req(1'b0, 2'b01, 1'b0, 12'h013, 32'h0, 0, "lh_misalign");
        do_req(1'b0, 2'b11, 1'b0, 12'h010, 32'h0, 0, "size_bad");
        do_req(1'b1, 2'b10, 1'b0, 12'h012, 32'h1234, 0, "sw_misalign");
        do_req(1'b0, 2'b10, 1'b0, 12'h014, 32'h0, 10, "lw_hold");

        // Reset while the write of a half store is on the BRAM port
        bwrite(7, 32'hCAFEF00D);
        drive_req(1'b1, 2'b01, 1'b0, 12'h01E, 32'h1357, "sh_rst");
        cyc = 0;
        while (!po_bram_we && cyc < 10) begin
            @(posedge pi_clk); #1; cyc++;
        end
        chk("sh_rst/in_wr", 32'(po_bram_we), 32'd1);
        pi_rst = 1'b1;
        @(posedge pi_clk); #1;
        chk_reset_outputs("sh_rst");
        pi_rst = 1'b0;
        @(posedge pi_clk); #1;
        chk("sh_rst/word7", ram[7], 32'hCAFEF00D);
        chk("sh_rst/idle", 32'(lsu_bus.po_req_ready), 32'd1);

        // Random traffic over a small window so RMW hits reused words
        for (int n = 0; n < 150; n++) begin
            logic [11:0] a;
            a = {WADDR'($urandom_range(0, NWORDS - 1)), 2'($urandom)};
            do_req(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
                   int'($urandom_range(0, 2)), "rand");
        end
        for (int i = 0; i < NWORDS; i++) chk("final_mem", ram[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
